// File: rtl/ocram_pattern_master_if.sv
// Avalon-MM link between the pattern master and the 32-bit on-chip RAM.
//   avm_address      word address
//   avm_byteenable   4'hF during a request, else 0
//   avm_chipselect   high with avm_read or avm_write
//   avm_write        write request, avm_writedata carries the data
//   avm_read         read request, avm_readdata returns after a fixed latency
//   avm_waitrequest  slave stall; the master holds the request while high
interface ocram_pattern_master_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_chipselect;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic              avm_read;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_byteenable, avm_chipselect,
           avm_write, avm_writedata, avm_read,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_byteenable, avm_chipselect,
           avm_write, avm_writedata, avm_read,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/ocram_pattern_master.sv
// RAM bring-up master: fills a word range with seed+i, reads it back and
// counts mismatching words, remembering the first failing address.
//   clk, reset_n      system clock, async active-low reset
//   start, abort      1-cycle request (IDLE only) / synchronous cancel
//   mode              0 fill+check, 1 check only, 2 fill only, 3 as 0
//   base_addr, length first word address, word count (0..2^ADDR_W)
//   seed              pattern seed
//   busy, done        operation in progress / 1-cycle completion pulse
//   err_count         mismatching words of the last check
//   first_err_addr    address of the first mismatch
//   avm               Avalon-MM master port
//
// state   | meaning
// S_IDLE  | waiting for start, no bus activity
// S_WRITE | issuing one write per accepted transfer
// S_READ  | issuing back-to-back reads, expected data pushed into the pipe
// S_FLUSH | no requests, draining outstanding read returns
// S_DONE  | one-cycle done pulse
module ocram_pattern_master #(
  parameter int ADDR_W       = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          mode,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  input  logic [31:0]         seed,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  ocram_pattern_master_if.master avm
);

  localparam logic [ADDR_W:0] ONE = 1;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_FLUSH, S_DONE} state_t;

  state_t              state, state_nx;
  logic [1:0]          mode_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     len_q;
  logic [31:0]         seed_q;
  logic [ADDR_W:0]     idx_q, idx_nx;
  logic                do_write, do_read, accept_rd, last, mismatch;
  logic [ADDR_W-1:0]   cur_addr;
  logic [31:0]         cur_data;

  // Read-return pipe: entry k reaches the last stage exactly when the slave
  // presents its data, so no handshake on the return path is needed.
  logic [READ_LATENCY-1:0] pv;
  logic [31:0]             pd [READ_LATENCY];
  logic [ADDR_W-1:0]       pa [READ_LATENCY];

  assign cur_addr  = base_q + idx_q[ADDR_W-1:0];
  assign cur_data  = seed_q + 32'(idx_q);
  assign last      = (idx_q == len_q - ONE);
  assign accept_rd = do_read && !avm.avm_waitrequest;
  assign mismatch  = pv[READ_LATENCY-1] && !abort &&
                     (avm.avm_readdata != pd[READ_LATENCY-1]);

  always_comb begin
    state_nx = state;
    idx_nx   = idx_q;
    do_write = 1'b0;
    do_read  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          idx_nx = '0;
          if (length == '0)      state_nx = S_DONE;
          else if (mode == 2'd1) state_nx = S_READ;
          else                   state_nx = S_WRITE;
        end
      end
      S_WRITE: begin
        do_write = 1'b1;
        if (!avm.avm_waitrequest) begin
          if (last) begin
            idx_nx   = '0;
            state_nx = (mode_q == 2'd2) ? S_DONE : S_READ;
          end else begin
            idx_nx = idx_q + ONE;
          end
        end
      end
      S_READ: begin
        do_read = 1'b1;
        if (!avm.avm_waitrequest) begin
          if (last) begin
            idx_nx   = '0;
            state_nx = S_FLUSH;
          end else begin
            idx_nx = idx_q + ONE;
          end
        end
      end
      S_FLUSH: if (pv == '0) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    // Abort wins over everything and kills the request in the same cycle.
    if (abort) begin
      state_nx = S_IDLE;
      do_write = 1'b0;
      do_read  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      idx_q          <= '0;
      mode_q         <= '0;
      base_q         <= '0;
      len_q          <= '0;
      seed_q         <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      state <= state_nx;
      idx_q <= idx_nx;
      if (state == S_IDLE && start && !abort) begin
        mode_q         <= (mode == 2'd3) ? 2'd0 : mode;
        base_q         <= base_addr;
        len_q          <= length;
        seed_q         <= seed;
        err_count      <= '0;
        first_err_addr <= '0;
      end else if (mismatch) begin
        err_count <= err_count + ONE;
        if (err_count == '0) first_err_addr <= pa[READ_LATENCY-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pv <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        pd[k] <= '0;
        pa[k] <= '0;
      end
    end else if (abort) begin
      pv <= '0;
    end else begin
      for (int k = READ_LATENCY - 1; k > 0; k--) begin
        pv[k] <= pv[k-1];
        pd[k] <= pd[k-1];
        pa[k] <= pa[k-1];
      end
      pv[0] <= accept_rd;
      pd[0] <= cur_data;
      pa[0] <= cur_addr;
    end
  end

  assign busy                = (state != S_IDLE);
  assign done                = (state == S_DONE);
  assign avm.avm_write       = do_write;
  assign avm.avm_read        = do_read;
  assign avm.avm_chipselect  = do_write | do_read;
  assign avm.avm_byteenable  = (do_write | do_read) ? 4'hF : 4'h0;
  assign avm.avm_address     = (do_write | do_read) ? cur_addr : '0;
  assign avm.avm_writedata   = do_write ? cur_data : '0;

endmodule

// File: tb/tb_ocram_pattern_master.sv
module tb_ocram_pattern_master;
  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0;
  logic [1:0]    mode = '0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic [31:0]   seed = '0;
  logic          busy, done;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_addr;

  ocram_pattern_master_if #(.ADDR_W(AW)) bus ();

  ocram_pattern_master #(.ADDR_W(AW), .READ_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .mode(mode), .base_addr(base_addr), .length(length), .seed(seed),
    .busy(busy), .done(done), .err_count(err_count),
    .first_err_addr(first_err_addr), .avm(bus.master)
  );

  // RAM model: 1-cycle read latency, optional alternating waitrequest
  bit [31:0]     mem [4096];
  logic [31:0]   ram_rd = '0;
  logic          ram_wait = 1'b0;
  logic          stall_en = 1'b0;
  logic          poke_req = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [31:0]   poke_val = '0;

  assign bus.avm_readdata    = ram_rd;
  assign bus.avm_waitrequest = ram_wait;

  always @(posedge clk) begin
    if (poke_req) mem[poke_addr] <= poke_val;
    if (bus.avm_chipselect && !ram_wait) begin
      if (bus.avm_write) mem[bus.avm_address] <= bus.avm_writedata;
      if (bus.avm_read)  ram_rd <= mem[bus.avm_address];
    end
    ram_wait <= stall_en ? ~ram_wait : 1'b0;
  end

  // Bus monitor
  int            wr_cnt = 0, rd_cnt = 0, done_cnt = 0, cs_cycles = 0;
  int            rule_bad = 0, stall_bad = 0;
  logic [AW-1:0] wr_addr [$];
  logic [31:0]   wr_data [$];
  logic          prev_stall = 1'b0;
  logic [AW+33:0] saved = '0;
  logic [AW+33:0] fields;
  assign fields = {bus.avm_write, bus.avm_read, bus.avm_address, bus.avm_writedata};

  always @(negedge clk) begin
    if (bus.avm_chipselect) cs_cycles++;
    if (bus.avm_write && bus.avm_read) rule_bad++;
    if (bus.avm_chipselect !== (bus.avm_write | bus.avm_read)) rule_bad++;
    if (bus.avm_byteenable !== (bus.avm_chipselect ? 4'hF : 4'h0)) rule_bad++;
    if (done) done_cnt++;
    if (bus.avm_write && !ram_wait) begin
      wr_cnt++;
      wr_addr.push_back(bus.avm_address);
      wr_data.push_back(bus.avm_writedata);
    end
    if (bus.avm_read && !ram_wait) rd_cnt++;
    if (prev_stall && fields !== saved) stall_bad++;
    prev_stall = bus.avm_chipselect && ram_wait;
    saved      = fields;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [1:0] m, input logic [AW-1:0] b,
                        input logic [AW:0] l, input logic [31:0] s);
    @(negedge clk);
    mode = m; base_addr = b; length = l; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // scramble inputs: the run must use the latched values
    mode = ~m; base_addr = ~b; length = l + 1; seed = ~s;
  endtask

  task automatic wait_done(input string tag);
    int n;
    for (n = 0; n < 500; n++) begin
      if (done === 1'b1) break;
      @(negedge clk);
    end
    check({tag, "_finished"}, 32'(n < 500), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_reads(input string tag, input int r0, input int target);
    logic hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk);
      if (rd_cnt - r0 >= target) hit = 1'b1;
    end
    check({tag, "_reach"}, 32'(hit), 32'd1);
  endtask

  int w0, r0, d0, c0;

  initial begin
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_first", 32'(first_err_addr), 32'd0);
    check("rst_cs", 32'(bus.avm_chipselect), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // 1: fill + check, 16 words from 0
    w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
    launch(2'd0, 12'h000, 13'd16, 32'h1000_0000);
    wait_done("t1");
    check("t1_writes", 32'(wr_cnt - w0), 32'd16);
    check("t1_reads", 32'(rd_cnt - r0), 32'd16);
    check("t1_done", 32'(done_cnt - d0), 32'd1);
    check("t1_err", 32'(err_count), 32'd0);
    for (int i = 0; i < 16; i++) begin
      check("t1_addr", 32'(wr_addr[w0+i]), 32'(i));
      check("t1_data", wr_data[w0+i], 32'h1000_0000 + 32'(i));
    end

    // 2: corrupt word 5, check only
    @(negedge clk); poke_addr = 12'h005; poke_val = 32'h0; poke_req = 1'b1;
    @(negedge clk); poke_req = 1'b0;
    w0 = wr_cnt; r0 = rd_cnt;
    launch(2'd1, 12'h000, 13'd16, 32'h1000_0000);
    wait_done("t2");
    check("t2_err", 32'(err_count), 32'd1);
    check("t2_first", 32'(first_err_addr), 32'h005);
    check("t2_writes", 32'(wr_cnt - w0), 32'd0);
    check("t2_reads", 32'(rd_cnt - r0), 32'd16);

    // 4: address wrap, fill only, then check only
    w0 = wr_cnt; r0 = rd_cnt;
    launch(2'd2, 12'hFFE, 13'd4, 32'hA5A5_A5A5);
    wait_done("t4");
    check("t4_writes", 32'(wr_cnt - w0), 32'd4);
    check("t4_reads", 32'(rd_cnt - r0), 32'd0);
    check("t4_err_clr", 32'(err_count), 32'd0);
    check("t4_a0", 32'(wr_addr[w0]),   32'hFFE);
    check("t4_a1", 32'(wr_addr[w0+1]), 32'hFFF);
    check("t4_a2", 32'(wr_addr[w0+2]), 32'h000);
    check("t4_a3", 32'(wr_addr[w0+3]), 32'h001);
    check("t4_d0", wr_data[w0],   32'hA5A5_A5A5);
    check("t4_d3", wr_data[w0+3], 32'hA5A5_A5A8);
    r0 = rd_cnt;
    launch(2'd1, 12'hFFE, 13'd4, 32'hA5A5_A5A5);
    wait_done("t4c");
    check("t4c_reads", 32'(rd_cnt - r0), 32'd4);
    check("t4c_err", 32'(err_count), 32'd0);

    // 3: stalls every other cycle, mode 3 behaves as fill + check
    stall_en = 1'b1;
    w0 = wr_cnt; r0 = rd_cnt;
    launch(2'd3, 12'h100, 13'd16, 32'h0BAD_0000);
    wait_done("t3");
    stall_en = 1'b0;
    check("t3_writes", 32'(wr_cnt - w0), 32'd16);
    check("t3_reads", 32'(rd_cnt - r0), 32'd16);
    check("t3_err", 32'(err_count), 32'd0);
    check("t3_a15", 32'(wr_addr[w0+15]), 32'h10F);
    check("t3_d15", wr_data[w0+15], 32'h0BAD_000F);
    check("t3_stable", 32'(stall_bad), 32'd0);

    // 5: zero length, start held while busy
    c0 = cs_cycles; d0 = done_cnt;
    @(negedge clk); length = '0; mode = 2'd0; start = 1'b1;
    @(negedge clk);
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_done", 32'(done), 32'd1);
    @(negedge clk); start = 1'b0;
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_done_off", 32'(done), 32'd0);
    @(negedge clk);
    check("t5_still_idle", 32'(busy), 32'd0);
    check("t5_no_cs", 32'(cs_cycles - c0), 32'd0);
    check("t5_one_done", 32'(done_cnt - d0), 32'd1);

    // 6a: abort during read phase
    d0 = done_cnt; r0 = rd_cnt;
    launch(2'd0, 12'h200, 13'd16, 32'h3333_0000);
    wait_reads("t6a", r0, 7);
    abort = 1'b1;
    #1 check("t6a_req_drop", 32'(bus.avm_chipselect), 32'd0);
    @(negedge clk); abort = 1'b0;
    check("t6a_idle", 32'(busy), 32'd0);
    c0 = cs_cycles;
    repeat (5) @(negedge clk);
    check("t6a_quiet", 32'(cs_cycles - c0), 32'd0);
    check("t6a_no_done", 32'(done_cnt - d0), 32'd0);
    check("t6a_err_hold", 32'(err_count), 32'd0);
    d0 = done_cnt;
    launch(2'd0, 12'h200, 13'd16, 32'h4444_0000);
    wait_done("t6a_rerun");
    check("t6a_rerun_err", 32'(err_count), 32'd0);
    check("t6a_rerun_done", 32'(done_cnt - d0), 32'd1);

    // 6b: reset during read phase
    d0 = done_cnt; r0 = rd_cnt;
    launch(2'd0, 12'h300, 13'd16, 32'h5555_0000);
    wait_reads("t6b", r0, 7);
    reset_n = 1'b0;
    #1;
    check("t6b_req_drop", 32'(bus.avm_chipselect), 32'd0);
    check("t6b_busy", 32'(busy), 32'd0);
    check("t6b_err", 32'(err_count), 32'd0);
    c0 = cs_cycles;
    repeat (3) @(negedge clk);
    check("t6b_quiet", 32'(cs_cycles - c0), 32'd0);
    reset_n = 1'b1;
    check("t6b_no_done", 32'(done_cnt - d0), 32'd0);
    launch(2'd0, 12'h300, 13'd16, 32'h6666_0000);
    wait_done("t6b_rerun");
    check("t6b_rerun_err", 32'(err_count), 32'd0);

    check("bus_rules", 32'(rule_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
